// File: rtl/spi_pkg.sv
// Shared constants for the SPI transaction controller: byte width, state
// encoding and small counter helpers.
package spi_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_LAUNCH = 3'd3;
    localparam logic [2:0] ST_XFER   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;
    localparam logic [2:0] ST_HOLD   = 3'd6;

    // Remaining-byte decrement that sticks at zero instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_dec(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b0}}) ? {LEN_W{1'b0}} : (v - {{(LEN_W-1){1'b0}}, 1'b1});
    endfunction

    // Load value for the delay counter so that a timed state lasts exactly n
    // cycles (the counter expires when it reaches zero). n=0 loads zero.
    function automatic logic [CNT_W-1:0] dly_load(input int n);
        return (n > 0) ? CNT_W'(n - 1) : {CNT_W{1'b0}};
    endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter shared by the SETUP, GAP and HOLD timers.
// expired_o is high whenever the count has reached zero.
module spi_delay_cnt
    import spi_pkg::*;
(
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI transaction controller. Frames a run of i_Len bytes with
// chip select, paces bytes into a byte-level SPI master and returns the
// received bytes, with setup/gap/hold timing and an early-abort path.
module spi_txn_ctrl
    import spi_pkg::*;
#(
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int GAP_CLKS      = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Start,
    input  logic [LEN_W-1:0]  i_Len,
    input  logic              i_Abort,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_TX_Valid,
    output logic              o_TX_Ready,
    output logic [BYTE_W-1:0] o_RX_Byte,
    output logic              o_RX_DV,
    output logic              o_RX_Last,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Aborted,
    output logic              o_CS_n,
    output logic [BYTE_W-1:0] o_M_TX_Byte,
    output logic              o_M_TX_DV,
    input  logic              i_M_TX_Ready,
    input  logic              i_M_RX_DV,
    input  logic [BYTE_W-1:0] i_M_RX_Byte
);

    localparam bit               SKIP_SETUP = (CS_SETUP_CLKS == 0);
    localparam bit               SKIP_GAP   = (GAP_CLKS == 0);
    localparam logic [CNT_W-1:0] SETUP_LD   = dly_load(CS_SETUP_CLKS);
    localparam logic [CNT_W-1:0] GAP_LD     = dly_load(GAP_CLKS);
    // A zero hold still spends one cycle in HOLD so done/CS release stay registered.
    localparam logic [CNT_W-1:0] HOLD_LD    = dly_load(CS_HOLD_CLKS);

    logic [2:0]        state_q,      state_d;
    logic [LEN_W-1:0]  rem_q,        rem_d;
    logic              rx_seen_q,    rx_seen_d;
    logic              abort_pend_q, abort_pend_d;
    logic              cs_n_q,       cs_n_d;
    logic              busy_q,       busy_d;
    logic [BYTE_W-1:0] m_tx_byte_q,  m_tx_byte_d;
    logic              m_tx_dv_q,    m_tx_dv_d;
    logic [BYTE_W-1:0] rx_byte_q,    rx_byte_d;
    logic              rx_dv_q,      rx_dv_d;
    logic              rx_last_q,    rx_last_d;
    logic              done_q,       done_d;
    logic              aborted_q,    aborted_d;

    logic              dly_load_s;
    logic [CNT_W-1:0]  dly_val_s;
    logic              dly_expired_s;
    logic              tx_ready_s;

    spi_delay_cnt u_delay (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .load_i     (dly_load_s),
        .load_val_i (dly_val_s),
        .expired_o  (dly_expired_s)
    );

    // Byte request is only offered while fetching and the master can take it.
    assign tx_ready_s = (state_q == ST_FETCH) && i_M_TX_Ready;

    // Transaction sequencing: next state, counters and output pulses.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        rx_seen_d    = rx_seen_q;
        abort_pend_d = abort_pend_q;
        cs_n_d       = cs_n_q;
        busy_d       = busy_q;
        m_tx_byte_d  = m_tx_byte_q;
        rx_byte_d    = rx_byte_q;
        m_tx_dv_d    = 1'b0;
        rx_dv_d      = 1'b0;
        rx_last_d    = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        dly_load_s   = 1'b0;
        dly_val_s    = {CNT_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (i_Start && (i_Len != {LEN_W{1'b0}})) begin
                    rem_d        = i_Len;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    abort_pend_d = 1'b0;
                    if (SKIP_SETUP) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d    = ST_SETUP;
                        dly_load_s = 1'b1;
                        dly_val_s  = SETUP_LD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (i_Abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_HOLD;
                    dly_load_s   = 1'b1;
                    dly_val_s    = HOLD_LD;
                end else if (dly_expired_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_SETUP;
                end
            end

            ST_FETCH: begin
                if (i_Abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_HOLD;
                    dly_load_s   = 1'b1;
                    dly_val_s    = HOLD_LD;
                end else if (i_TX_Valid && tx_ready_s) begin
                    m_tx_byte_d = i_TX_Byte;
                    state_d     = ST_LAUNCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_LAUNCH: begin
                // Launch pulse is seen by the master during the first XFER cycle.
                m_tx_dv_d = 1'b1;
                rx_seen_d = 1'b0;
                state_d   = ST_XFER;
                if (i_Abort) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
            end

            ST_XFER: begin
                if (i_Abort) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                // Master ready is only looked at after its received-byte pulse,
                // so the stale ready around the launch pulse is never used.
                if (!rx_seen_q) begin
                    if (i_M_RX_DV) begin
                        rx_seen_d = 1'b1;
                        rx_byte_d = i_M_RX_Byte;
                        rx_dv_d   = 1'b1;
                        rx_last_d = (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) && !abort_pend_q && !i_Abort;
                        rem_d     = sat_dec(rem_q);
                    end else begin
                        rx_seen_d = 1'b0;
                    end
                end else if (i_M_TX_Ready) begin
                    if (abort_pend_q || i_Abort || (rem_q == {LEN_W{1'b0}})) begin
                        state_d    = ST_HOLD;
                        dly_load_s = 1'b1;
                        dly_val_s  = HOLD_LD;
                    end else if (SKIP_GAP) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d    = ST_GAP;
                        dly_load_s = 1'b1;
                        dly_val_s  = GAP_LD;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end

            ST_GAP: begin
                if (i_Abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_HOLD;
                    dly_load_s   = 1'b1;
                    dly_val_s    = HOLD_LD;
                end else if (dly_expired_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_GAP;
                end
            end

            ST_HOLD: begin
                if (dly_expired_s) begin
                    state_d      = ST_IDLE;
                    cs_n_d       = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    aborted_d    = abort_pend_q;
                    abort_pend_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset releases chip select immediately.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            rem_q        <= {LEN_W{1'b0}};
            rx_seen_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            m_tx_byte_q  <= {BYTE_W{1'b0}};
            m_tx_dv_q    <= 1'b0;
            rx_byte_q    <= {BYTE_W{1'b0}};
            rx_dv_q      <= 1'b0;
            rx_last_q    <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            rx_seen_q    <= rx_seen_d;
            abort_pend_q <= abort_pend_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            m_tx_byte_q  <= m_tx_byte_d;
            m_tx_dv_q    <= m_tx_dv_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            rx_last_q    <= rx_last_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign o_TX_Ready  = tx_ready_s;
    assign o_RX_Byte   = rx_byte_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Last   = rx_last_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Aborted   = aborted_q;
    assign o_CS_n      = cs_n_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl with a loopback byte-level master model.
module tb_spi_txn_ctrl;

    localparam int S = 4;
    localparam int H = 4;
    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       abort;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_last;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       cs_n;
    logic [7:0] m_tx_byte;
    logic       m_tx_dv;
    logic       m_rdy;
    logic       m_rx_dv;
    logic [7:0] m_rx_byte;

    spi_txn_ctrl #(.CS_SETUP_CLKS(S), .CS_HOLD_CLKS(H), .GAP_CLKS(G)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Len(len), .i_Abort(abort),
        .i_TX_Byte(tx_byte), .i_TX_Valid(tx_valid), .o_TX_Ready(tx_ready),
        .o_RX_Byte(rx_byte), .o_RX_DV(rx_dv), .o_RX_Last(rx_last), .o_Busy(busy),
        .o_Done(done), .o_Aborted(aborted), .o_CS_n(cs_n),
        .o_M_TX_Byte(m_tx_byte), .o_M_TX_DV(m_tx_dv), .i_M_TX_Ready(m_rdy),
        .i_M_RX_DV(m_rx_dv), .i_M_RX_Byte(m_rx_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback master: busy for ~10 cycles per byte, echoes the sent byte.
    logic [3:0] m_cnt;
    logic [7:0] m_shift;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 1'b1; m_cnt <= 4'd0; m_rx_dv <= 1'b0; m_rx_byte <= 8'h00; m_shift <= 8'h00;
        end else begin
            m_rx_dv <= 1'b0;
            if (m_tx_dv && m_rdy) begin
                m_rdy <= 1'b0; m_cnt <= 4'd8; m_shift <= m_tx_byte;
            end else if (!m_rdy) begin
                if (m_cnt == 4'd1) begin m_rx_dv <= 1'b1; m_rx_byte <= m_shift; end
                if (m_cnt == 4'd0) m_rdy <= 1'b1;
                else m_cnt <= m_cnt - 4'd1;
            end
        end
    end

    // Byte source fed from a small table.
    logic [7:0] tx_mem [0:15];
    logic [4:0] tx_idx = 5'd0;
    logic [4:0] tx_cnt = 5'd0;
    logic       tx_en  = 1'b0;
    logic       tx_clr = 1'b0;
    assign tx_valid = tx_en && (tx_idx < tx_cnt);
    assign tx_byte  = tx_mem[tx_idx[3:0]];
    always @(posedge clk) begin
        if (tx_clr) tx_idx <= 5'd0;
        else if (tx_valid && tx_ready) tx_idx <= tx_idx + 5'd1;
    end

    // Output monitor, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    logic [7:0]  rx_q [0:15];
    logic [15:0] last_mask;
    int rx_n, done_n, stray_ab, stray_last, cs_fall_n, cs_rise_n, dv_n, dv_wide;
    int cs_fall_cyc, first_dv_cyc, last_mrx_cyc, hold_cyc, min_gap;
    logic abort_at_done, busy_at_done, cs_at_done;
    logic prev_cs = 1'b1;
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        if (mon_clr) begin
            last_mask = 16'h0000; rx_n = 0; done_n = 0; stray_ab = 0; stray_last = 0;
            cs_fall_n = 0; cs_rise_n = 0; dv_n = 0; dv_wide = 0; cs_fall_cyc = 0;
            first_dv_cyc = 0; last_mrx_cyc = 0; hold_cyc = 0; min_gap = 100000;
            abort_at_done = 1'b0; busy_at_done = 1'b1; cs_at_done = 1'b0;
        end else begin
            if (rx_dv) begin
                rx_q[rx_n[3:0]] = rx_byte;
                if (rx_last) last_mask[rx_n[3:0]] = 1'b1;
                rx_n++;
            end else if (rx_last) stray_last++;
            if (done) begin
                done_n++; abort_at_done = aborted; busy_at_done = busy; cs_at_done = cs_n;
            end else if (aborted) stray_ab++;
            if (prev_cs && !cs_n) begin cs_fall_n++; cs_fall_cyc = cyc; end
            if (!prev_cs && cs_n) begin cs_rise_n++; hold_cyc = cyc - last_mrx_cyc; end
            if (m_tx_dv) begin
                if (dv_n == 0) first_dv_cyc = cyc;
                else if ((cyc - last_mrx_cyc) < min_gap) min_gap = cyc - last_mrx_cyc;
                dv_n++;
                if (prev_dv) dv_wide++;
            end
            if (m_rx_dv) last_mrx_cyc = cyc;
        end
        prev_cs = cs_n;
        prev_dv = m_tx_dv;
    end

    int n_chk = 0;
    int n_err = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic prep();
        @(negedge clk); tx_en = 1'b0; tx_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b1;
        @(negedge clk); tx_clr = 1'b0;
        @(posedge clk); mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] l);
        @(negedge clk); start = 1'b1; len = l; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            @(negedge clk); #1;
            if (done_n > 0) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic wait_dv(input int n, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            @(negedge clk); #1;
            if (dv_n >= n) seen = 1'b1;
        end
        chk("dv_seen", seen, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 4'd0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1);       chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0); chk("rst_m_tx_dv", m_tx_dv, 0);
        chk("rst_rx_dv", rx_dv, 0);     chk("rst_rx_last", rx_last, 0);
        chk("rst_done", done, 0);       chk("rst_aborted", aborted, 0);
        chk("rst_rx_byte", rx_byte, 0); chk("rst_m_tx_byte", m_tx_byte, 0);
        rst_n = 1'b1;
        prep();

        // Three-byte loopback with timing measurements.
        tx_mem[0] = 8'h20; tx_mem[1] = 8'h00; tx_mem[2] = 8'h11;
        tx_cnt = 5'd3; tx_en = 1'b1;
        do_start(4'd3);
        wait_done(2000);
        chk("a_rx_n", rx_n, 3);
        chk("a_rx0", rx_q[0], 8'h20); chk("a_rx1", rx_q[1], 8'h00); chk("a_rx2", rx_q[2], 8'h11);
        chk("a_last", last_mask, 16'h0004);
        chk("a_done_n", done_n, 1);
        chk("a_aborted", abort_at_done, 0);
        chk("a_busy_at_done", busy_at_done, 0);
        chk("a_cs_at_done", cs_at_done, 1);
        chk("a_cs_to_dv", first_dv_cyc - cs_fall_cyc, S + 2);
        chk("a_start_to_dv", first_dv_cyc - start_cyc, S + 3);
        chk("a_hold_ge", hold_cyc >= H, 1);
        chk("a_gap_ge", min_gap >= G, 1);
        chk("a_dv_n", dv_n, 3);
        chk("a_dv_wide", dv_wide, 0);
        chk("a_stray", stray_ab + stray_last, 0);

        // Nine-byte frame with a source stall before byte 5.
        prep();
        for (int i = 0; i < 9; i++) tx_mem[i] = 8'h30 + 8'(i);
        tx_cnt = 5'd4; tx_en = 1'b1;
        do_start(4'd9);
        wait_dv(4, 500);
        repeat (60) @(negedge clk);
        #1;
        chk("b_stall_cs_n", cs_n, 0);
        chk("b_stall_busy", busy, 1);
        chk("b_stall_dv_n", dv_n, 4);
        chk("b_stall_rise", cs_rise_n, 0);
        tx_cnt = 5'd9;
        wait_done(3000);
        chk("b_rx_n", rx_n, 9);
        for (int i = 0; i < 9; i++) chk("b_rx", rx_q[i], 8'h30 + 8'(i));
        chk("b_last", last_mask, 16'h0100);
        chk("b_cs_rise_n", cs_rise_n, 1);
        chk("b_aborted", abort_at_done, 0);

        // Abort during the second of four bytes.
        prep();
        for (int i = 0; i < 4; i++) tx_mem[i] = 8'h51 + 8'(i);
        tx_cnt = 5'd4; tx_en = 1'b1;
        do_start(4'd4);
        wait_dv(2, 500);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        wait_done(500);
        abort = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("c_rx_n", rx_n, 2);
        chk("c_rx1", rx_q[1], 8'h52);
        chk("c_last", last_mask, 16'h0000);
        chk("c_dv_n", dv_n, 2);
        chk("c_done_n", done_n, 1);
        chk("c_aborted", abort_at_done, 1);
        chk("c_stray_ab", stray_ab, 0);

        // Zero-length start and start while busy are ignored.
        prep();
        do_start(4'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("d_len0_fall", cs_fall_n, 0);
        chk("d_len0_done", done_n, 0);
        chk("d_len0_busy", busy, 0);
        tx_mem[0] = 8'h7E; tx_cnt = 5'd1; tx_en = 1'b1;
        do_start(4'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("d_busy", busy, 1);
        do_start(4'd5);
        wait_done(1000);
        repeat (40) @(negedge clk);
        #1;
        chk("d_rx_n", rx_n, 1);
        chk("d_rx0", rx_q[0], 8'h7E);
        chk("d_last", last_mask, 16'h0001);
        chk("d_cs_fall_n", cs_fall_n, 1);
        chk("d_dv_n", dv_n, 1);
        chk("d_done_n", done_n, 1);

        // Reset during byte 2, then a normal transaction.
        prep();
        for (int i = 0; i < 4; i++) tx_mem[i] = 8'h41 + 8'(i);
        tx_cnt = 5'd4; tx_en = 1'b1;
        do_start(4'd4);
        wait_dv(2, 500);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("e_cs_n", cs_n, 1);         chk("e_busy", busy, 0);
        chk("e_rx_dv", rx_dv, 0);       chk("e_m_tx_dv", m_tx_dv, 0);
        chk("e_tx_ready", tx_ready, 0); chk("e_done", done, 0);
        chk("e_rx_byte", rx_byte, 0);   chk("e_m_tx_byte", m_tx_byte, 0);
        chk("e_rx_last", rx_last, 0);   chk("e_aborted", aborted, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("e_no_done", done_n, 0);
        rst_n = 1'b1;
        prep();
        tx_mem[0] = 8'hA5; tx_mem[1] = 8'h5A; tx_cnt = 5'd2; tx_en = 1'b1;
        do_start(4'd2);
        wait_done(1000);
        chk("e2_rx_n", rx_n, 2);
        chk("e2_rx0", rx_q[0], 8'hA5);
        chk("e2_rx1", rx_q[1], 8'h5A);
        chk("e2_last", last_mask, 16'h0002);
        chk("e2_aborted", abort_at_done, 0);
        chk("e2_done_n", done_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_txn_ctrl.md
SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

Interface
REQ-001 SHALL have parameter CS_SETUP_CLKS, default 4: i_Clk cycles from o_CS_n fall to first byte launch.
REQ-002 SHALL have parameter CS_HOLD_CLKS, default 4: cycles from last byte completion to o_CS_n rise.
REQ-003 SHALL have parameter GAP_CLKS, default 16: idle cycles between consecutive bytes.
REQ-004 SHALL have ports; clock i_Clk, reset i_Rst_L asynchronous active-low:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle pulse, begin transaction
- i_Len  in  4  byte count, latched on accepted i_Start
- i_Abort  in  1  level, terminate transaction early
- i_TX_Byte  in  8  next byte to send
- i_TX_Valid  in  1  i_TX_Byte valid
- o_TX_Ready  out  1  byte accepted when high with i_TX_Valid
- o_RX_Byte  out  8  received byte
- o_RX_DV  out  1  one-cycle pulse, o_RX_Byte valid
- o_RX_Last  out  1  high with o_RX_DV on final byte
- o_Busy  out  1  transaction in progress
- o_Done  out  1  one-cycle pulse at end of transaction
- o_Aborted  out  1  high with o_Done if ended by i_Abort
- o_CS_n  out  1  active-low chip select
- o_M_TX_Byte  out  8  byte to byte-level SPI master
- o_M_TX_DV  out  1  one-cycle launch pulse to master
- i_M_TX_Ready  in  1  master idle
- i_M_RX_DV  in  1  master byte-received pulse
- i_M_RX_Byte  in  8  master received byte

Function
REQ-005 SHALL implement states IDLE, SETUP, FETCH, LAUNCH, XFER, GAP, HOLD.
REQ-006 IDLE: i_Start with i_Len!=0 SHALL latch i_Len, drive o_CS_n=0, o_Busy=1, go SETUP next cycle; i_Start with i_Len=0 SHALL be ignored.
REQ-007 i_Start while o_Busy=1 SHALL be ignored.
REQ-008 SETUP SHALL count CS_SETUP_CLKS cycles then enter FETCH.
REQ-009 FETCH: o_TX_Ready=1 only in FETCH and only when i_M_TX_Ready=1; on i_TX_Valid&o_TX_Ready SHALL register i_TX_Byte into o_M_TX_Byte and enter LAUNCH.
REQ-010 LAUNCH SHALL assert o_M_TX_DV for exactly one cycle, then enter XFER.
REQ-011 XFER SHALL wait for i_M_RX_DV, then for i_M_TX_Ready=1; master ready is not sampled in the cycle after o_M_TX_DV.
REQ-012 On i_M_RX_DV SHALL register i_M_RX_Byte to o_RX_Byte and pulse o_RX_DV next cycle; o_RX_Last=1 when the byte is number i_Len.
REQ-013 After byte completion with remaining count>0 SHALL enter GAP for GAP_CLKS cycles then FETCH; with remaining count=0 SHALL enter HOLD.
REQ-014 GAP_CLKS=0 or CS_SETUP_CLKS=0 SHALL skip the respective state directly.
REQ-015 HOLD SHALL count CS_HOLD_CLKS cycles, then drive o_CS_n=1, o_Busy=0, pulse o_Done, enter IDLE, all in the same cycle.
REQ-016 Remaining-byte counter SHALL be 4 bits, decremented once per completed byte; no wrap below 0.
REQ-017 i_Abort in SETUP, FETCH or GAP SHALL enter HOLD next cycle; in LAUNCH or XFER the current byte SHALL complete (o_RX_DV still pulses, o_RX_Last=0) before HOLD.
REQ-018 o_Aborted SHALL equal 1 with o_Done when the transaction ended via REQ-017, else 0.
REQ-019 i_TX_Valid low in FETCH SHALL stall indefinitely with o_CS_n held low.
REQ-020 End-to-end latency i_Start to first o_M_TX_DV with i_TX_Valid held high SHALL be CS_SETUP_CLKS+3 cycles.

Reset
REQ-021 Reset SHALL force IDLE, o_CS_n=1, o_Busy=0, o_TX_Ready=0, o_M_TX_DV=0, o_RX_DV=0, o_RX_Last=0, o_Done=0, o_Aborted=0, o_RX_Byte=0, o_M_TX_Byte=0, counters=0.
REQ-022 Reset mid-transaction SHALL release o_CS_n immediately (asynchronous) without o_Done.

Structure
REQ-023 State encoding constants SHALL reside in shared package spi_pkg, with the 8-bit byte width constant.
REQ-024 A single sub-module spi_delay_cnt (load/count/expire) SHALL be reused for SETUP, GAP and HOLD timing.

Verification
REQ-025 i_Len=3, bytes 0x20,0x00,0x11, master loopback MISO=MOSI -> three o_RX_DV with 0x20,0x00,0x11, o_RX_Last on third, one o_Done, o_Aborted=0.
REQ-026 Measure: o_CS_n fall to first o_M_TX_DV = CS_SETUP_CLKS+2 cycles; last i_M_RX_DV to o_CS_n rise >= CS_HOLD_CLKS cycles; byte-to-byte gap >= GAP_CLKS.
REQ-027 i_Len=9 (RDATA frame) with i_TX_Valid dropped 50 cycles before byte 5 -> stall, o_CS_n stays 0, all 9 bytes delivered.
REQ-028 i_Abort asserted mid-XFER of byte 2 of 4 -> byte 2 completes, o_RX_Last=0, no third o_M_TX_DV, o_Done with o_Aborted=1.
REQ-029 i_Start with i_Len=0, and i_Start while busy -> no o_CS_n change, no extra o_Done.
REQ-030 i_Rst_L low during byte 2 -> o_CS_n=1 same cycle, all outputs at reset values, next i_Start operates normally.
